// File: rtl/sub4bits_serial.sv
// sub4bits_serial: bit-serial subtractor, d = a - b, LSB first, one bit per clock.
// The result is {borrow_out, diff}, WIDTH+1 bits, held until the next done pulse.
// Optional build macro SUB4_ADD_MODE_EN adds an op input (0 = add, 1 = subtract).
module sub4bits_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SUB4_ADD_MODE_EN
    input  logic             op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   d
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   a_sr_q, a_sr_n;
    logic [WIDTH-1:0]   b_sr_q, b_sr_n;
    logic [WIDTH-1:0]   res_q, res_n;
    logic               br_q, br_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               busy_n;
    logic               done_n;
    logic [WIDTH:0]     d_n;
`ifdef SUB4_ADD_MODE_EN
    logic               op_q, op_n;
`endif

    logic               ai, bi, dbit, br_next;

    // Per-bit datapath: difference/sum bit and next borrow/carry from operand LSBs
    always_comb begin
        ai      = a_sr_q[0];
        bi      = b_sr_q[0];
        dbit    = ai ^ bi ^ br_q;
        br_next = (~ai & bi) | (~(ai ^ bi) & br_q);
`ifdef SUB4_ADD_MODE_EN
        if (!op_q) begin
            br_next = (ai & bi) | (ai & br_q) | (bi & br_q);
        end
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state_q;
        a_sr_n  = a_sr_q;
        b_sr_n  = b_sr_q;
        res_n   = res_q;
        br_n    = br_q;
        cnt_n   = cnt_q;
        busy_n  = busy;
        done_n  = 1'b0;
        d_n     = d;
`ifdef SUB4_ADD_MODE_EN
        op_n    = op_q;
`endif
        unique case (state_q)
            IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    a_sr_n  = a;
                    b_sr_n  = b;
                    br_n    = 1'b0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
`ifdef SUB4_ADD_MODE_EN
                    op_n    = op;
`endif
                end
            end
            SHIFT: begin
                busy_n = 1'b1;
                a_sr_n = a_sr_q >> 1;
                b_sr_n = b_sr_q >> 1;
                res_n  = {dbit, res_q[WIDTH-1:1]};
                br_n   = br_next;
                cnt_n  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    d_n     = {br_next, dbit, res_q[WIDTH-1:1]};
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            d       <= '0;
`ifdef SUB4_ADD_MODE_EN
            op_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_n;
            a_sr_q  <= a_sr_n;
            b_sr_q  <= b_sr_n;
            res_q   <= res_n;
            br_q    <= br_n;
            cnt_q   <= cnt_n;
            busy    <= busy_n;
            done    <= done_n;
            d       <= d_n;
`ifdef SUB4_ADD_MODE_EN
            op_q    <= op_n;
`endif
        end
    end

endmodule

// File: tb/tb_sub4bits_serial.sv
// Scoreboard bench for sub4bits_serial: stimulus pushes expected d, monitor pops on done.
module tb_sub4bits_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [4:0] d;

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];

    sub4bits_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SUB4_ADD_MODE_EN
        .op    (op),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("busy_low_on_done", int'(busy), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("d_value", int'(d), int'(exp_q.pop_front()));
            end
        end
    end

    // One operation with latency and busy-length checks; operands scrambled while busy
    task automatic do_op(input logic [3:0] av, input logic [3:0] bv, input logic opv,
                         input logic [4:0] expv);
        int k;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        op    = opv;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        a     = 4'($urandom);
        b     = 4'($urandom);
        op    = 1'($urandom);
        k        = 0;
        busy_cnt = 0;
        while (!done && k < 12) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            k++;
        end
        check("latency", k, 4);
        check("busy_cycles", busy_cnt, 4);
    endtask

    initial begin
        int       dn_idx[$];
        logic [4:0] e;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b1;
        a     = '0;
        b     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_d", int'(d), 0);
        rst_n = 1'b1;

        // Directed vectors
        do_op(4'd9,  4'd4,  1'b1, 5'b00101);
        do_op(4'd3,  4'd5,  1'b1, 5'b11110);
        do_op(4'd0,  4'd15, 1'b1, 5'b10001);
        do_op(4'd15, 4'd0,  1'b1, 5'b01111);
        do_op(4'd15, 4'd15, 1'b1, 5'b00000);

        // Start held high: accepted at edges 0, 5, 10 -> done every 5 cycles
        @(negedge clk);
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd2;
        op    = 1'b1;
        repeat (3) exp_q.push_back(5'b00101);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 10) start = 1'b0;
            if (done) dn_idx.push_back(i);
            if (dn_idx.size() == 3) break;
        end
        check("b2b_count", dn_idx.size(), 3);
        if (dn_idx.size() == 3) begin
            check("b2b_gap1", dn_idx[1] - dn_idx[0], 5);
            check("b2b_gap2", dn_idx[2] - dn_idx[1], 5);
        end

        // Abort: reset at the 2nd SHIFT edge, no done, d stays 0
        @(negedge clk);
        start = 1'b1;
        a     = 4'd12;
        b     = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_d", int'(d), 0);
        check("abort_busy", int'(busy), 0);
        do_op(4'd12, 4'd1, 1'b1, 5'b01011);

        // Exhaustive subtract
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                e = 5'(({1'b0, 4'(i)} - {1'b0, 4'(j)}) & 5'h1F);
                do_op(4'(i), 4'(j), 1'b1, e);
            end
        end
`ifdef SUB4_ADD_MODE_EN
        // Exhaustive add
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                e = 5'({1'b0, 4'(i)} + {1'b0, 4'(j)});
                do_op(4'(i), 4'(j), 1'b0, e);
            end
        end
`endif
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
